// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V pipeline: ALU operations, access widths and
// the execute-to-memory pipeline register payload.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_EQ    = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;

  localparam logic [1:0] WIDTH_B = 2'd0;
  localparam logic [1:0] WIDTH_H = 2'd1;
  localparam logic [1:0] WIDTH_W = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data0;
    logic [XLEN-1:0] data1;
    logic            read;
    logic            write;
    logic            extend;
    logic [1:0]      width;
    logic            jmp;
    logic            br;
    logic            br_inv;
    logic [4:0]      wb_reg;
  } ex_mem_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU; shift amount is b[4:0], arithmetic wraps.
import riscv_pkg::*;

module alu (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic        [4:0]      shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, a_s < b_s};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned(a_s >>> shamt);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_EQ:    result = {{(XLEN-1){1'b0}}, a == b};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/stage_execute.sv
// Execute stage: operand forwarding, ALU, branch/jump targets, load-use
// hazard detection and the registered memory-stage inputs.
import riscv_pkg::*;

module stage_execute (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [4:0]      ex_rs1,
  input  logic [4:0]      ex_rs2,
  input  logic [XLEN-1:0] ex_rdata1,
  input  logic [XLEN-1:0] ex_rdata2,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_use_imm,
  input  logic            ex_use_pc,
  input  logic [3:0]      ex_alu_op,
  input  logic            ex_read,
  input  logic            ex_write,
  input  logic            ex_extend,
  input  logic [1:0]      ex_width,
  input  logic            ex_jmp,
  input  logic            ex_jmp_reg,
  input  logic            ex_br,
  input  logic            ex_br_inv,
  input  logic [4:0]      ex_wb_reg,
  input  logic            fwd_mem_wen,
  input  logic [4:0]      fwd_mem_reg,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_mem_load,
  input  logic            fwd_wb_wen,
  input  logic [4:0]      fwd_wb_reg,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            mem_stall,
  input  logic            flush,
  output logic            ex_stall,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_pc,
  output logic [XLEN-1:0] mem_data0,
  output logic [XLEN-1:0] mem_data1,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_extend,
  output logic [1:0]      mem_width,
  output logic            mem_jmp,
  output logic            mem_br,
  output logic            mem_br_inv,
  output logic [4:0]      wb_reg
);

  logic [XLEN-1:0] rs1v, rs2v, op_a, op_b, alu_res;
  logic [XLEN-1:0] pc_imm, link, jmp_tgt;
  logic [3:0]      alu_op_eff;
  logic            hazard;
  ex_mem_t         pay_p0, pay_p1;
  logic            vld_p1;

  // Memory-stage forward beats write-stage forward; x0 never forwards.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]      idx,
                                              input logic [XLEN-1:0] rf);
    if (idx == 5'd0)                              return '0;
    else if (fwd_mem_wen && fwd_mem_reg == idx)   return fwd_mem_data;
    else if (fwd_wb_wen && fwd_wb_reg == idx)     return fwd_wb_data;
    else                                          return rf;
  endfunction

  assign rs1v = fwd_sel(ex_rs1, ex_rdata1);
  assign rs2v = fwd_sel(ex_rs2, ex_rdata2);
  assign op_a = ex_use_pc  ? ex_pc  : rs1v;
  assign op_b = ex_use_imm ? ex_imm : rs2v;

  // Loads and stores always need an address add, whatever op decode chose.
  assign alu_op_eff = (ex_read || ex_write) ? ALU_ADD : ex_alu_op;

  alu u_alu (
    .op     (alu_op_eff),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res)
  );

  assign pc_imm  = ex_pc + ex_imm;
  assign link    = ex_pc + 32'd4;
  assign jmp_tgt = ex_jmp_reg ? ((rs1v + ex_imm) & ~32'd1) : pc_imm;

  assign hazard = ex_valid && fwd_mem_load && (fwd_mem_reg != 5'd0) &&
                  ((fwd_mem_reg == ex_rs1) || (fwd_mem_reg == ex_rs2));

  assign ex_stall = ex_valid && !flush && (mem_stall || hazard);

  always_comb begin
    pay_p0        = '0;
    pay_p0.pc     = ex_pc;
    pay_p0.data0  = ex_jmp ? link : alu_res;
    pay_p0.data1  = ex_jmp ? jmp_tgt : (ex_br ? pc_imm : rs2v);
    pay_p0.read   = ex_read;
    pay_p0.write  = ex_write;
    pay_p0.extend = ex_extend;
    pay_p0.width  = ex_width;
    pay_p0.jmp    = ex_jmp;
    pay_p0.br     = ex_br;
    pay_p0.br_inv = ex_br_inv;
    pay_p0.wb_reg = ex_wb_reg;
  end

  // p0 -> p1: memory-stage input register; reset overrides a held stall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      pay_p1 <= '0;
    end else if (!mem_stall) begin
      vld_p1 <= ex_valid && !hazard && !flush;
      pay_p1 <= pay_p0;
    end
  end

  assign mem_valid  = vld_p1;
  assign mem_pc     = pay_p1.pc;
  assign mem_data0  = pay_p1.data0;
  assign mem_data1  = pay_p1.data1;
  assign mem_read   = pay_p1.read;
  assign mem_write  = pay_p1.write;
  assign mem_extend = pay_p1.extend;
  assign mem_width  = pay_p1.width;
  assign mem_jmp    = pay_p1.jmp;
  assign mem_br     = pay_p1.br;
  assign mem_br_inv = pay_p1.br_inv;
  assign wb_reg     = pay_p1.wb_reg;

endmodule

// File: doc/stage_execute.md
# stage_execute

Execute stage of the in-order RISC-V pipeline, between decode and the memory stage. It selects operands (register file, immediate, PC) with forwarding from the memory and write stages, runs the ALU and the branch/jump target adder, and registers the result into the memory-stage input register (`mem_*`). It detects the load-use hazard, propagates the memory stage's stall back to decode, and drops its instruction when the memory stage redirects the PC.

## Interface
Parameters: none.

- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `ex_valid`  in  1  decode presents an instruction
- `ex_pc`  in  32  instruction PC
- `ex_rs1`, `ex_rs2`  in  5 each  source register indices
- `ex_rdata1`, `ex_rdata2`  in  32 each  register file read data
- `ex_imm`  in  32  sign-extended immediate
- `ex_use_imm`  in  1  ALU operand B = `ex_imm` (else rs2 value)
- `ex_use_pc`  in  1  ALU operand A = `ex_pc` (else rs1 value)
- `ex_alu_op`  in  4  ALU operation, encoded in the package
- `ex_read`, `ex_write`, `ex_extend`  in  1 each  load / store / sign-extend load
- `ex_width`  in  2  access width
- `ex_jmp`, `ex_jmp_reg`  in  1 each  jump; target taken from rs1 (JALR)
- `ex_br`, `ex_br_inv`  in  1 each  conditional branch; invert condition
- `ex_wb_reg`  in  5  destination register
- `fwd_mem_wen`, `fwd_mem_reg`, `fwd_mem_data`  in  1/5/32  memory-stage ALU result forward
- `fwd_mem_load`  in  1  memory stage holds a valid load
- `fwd_wb_wen`, `fwd_wb_reg`, `fwd_wb_data`  in  1/5/32  write-stage forward
- `mem_stall`  in  1  memory stage cannot accept
- `flush`  in  1  memory stage PC write (`pc_wen`)
- `ex_stall`  out  1  decode must hold its instruction
- `mem_valid`, `mem_pc`, `mem_data0`, `mem_data1`, `mem_read`, `mem_write`, `mem_extend`, `mem_width`, `mem_jmp`, `mem_br`, `mem_br_inv`, `wb_reg`  out  registered memory-stage inputs

## Operation
- **Forwarding (per source):** the memory-stage forward wins over the write-stage forward, which wins over `ex_rdata`. A forward is used only when its wen is set, its reg equals the source index, and the index is non-zero. x0 is always read as 0.
- **ALU:** A = `ex_use_pc` ? `ex_pc` : rs1v; B = `ex_use_imm` ? `ex_imm` : rs2v.
  - Ops: ADD, SUB, SLL, SLT (signed), SLTU, XOR, SRL, SRA, OR, AND, EQ (result = {31'b0, A==B}), PASSB.
  - Shift amount is B[4:0]. All arithmetic is 32-bit with wraparound.
- **Result routing (`mem_data0` / `mem_data1`):**
  - Load/store: data0 = A+B (ALU ADD), data1 = rs2v (store data).
  - Jump: data0 = `ex_pc`+4 (link value). data1 = `ex_jmp_reg` ? (rs1v+`ex_imm`) & ~1 : `ex_pc`+`ex_imm`.
  - Branch: data0 = ALU result (condition in bit 0), data1 = `ex_pc`+`ex_imm`.
  - Otherwise: data0 = ALU result, data1 = rs2v.
- **Load-use hazard:** `hazard` = `ex_valid` & `fwd_mem_load` & `fwd_mem_reg`≠0 & (`fwd_mem_reg`==`ex_rs1` | `fwd_mem_reg`==`ex_rs2`). Both indices are compared unconditionally; a spurious stall is acceptable.
- **Stall and flow:**
  - `ex_stall` = `ex_valid` & ~`flush` & (`mem_stall` | `hazard`).
  - If `mem_stall`, all `mem_*` registers hold.
  - Otherwise `mem_valid` <= `ex_valid` & ~`hazard` & ~`flush`, and the payload registers load every cycle (payload is don't-care when invalid).
- **Flush:** the instruction in execute is discarded (not stalled). The target instruction arrives later from fetch.
- **Reset:** `mem_valid`=0 and every payload output = 0. `ex_stall` is combinational, so it is 0 whenever `ex_valid`=0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on `mem_*` after edge N.
- A hazard inserts exactly one bubble (`mem_valid`=0) per cycle that `fwd_mem_load` matches. The following cycle the write-stage forward supplies the loaded data.
- `mem_stall` and `flush` in the same cycle: the `mem_*` registers hold, and the execute instruction is dropped (`ex_stall`=0).
- Reset mid-stall: `mem_valid` is 0 on the next edge, regardless of `mem_stall`.

## Structure
- Shared package `riscv_pkg`: the ALU op encodings (4-bit localparams) and the width encodings shared with the memory stage.
- One sub-module, `alu`: purely combinational, inputs `op`/`a`/`b`, output `result`.
- Forward muxes, target adders and the pipeline register stay in `stage_execute`.

## Test plan
- ADD x3=x1+x2 with x1=5, x2=7, no forwards -> `mem_valid`=1, `mem_data0`=12, `wb_reg`=3 one cycle later.
- SUB with `fwd_mem_wen`=1, `fwd_mem_reg`=1, data 100, plus `fwd_wb_reg`=1, data 50, rs2=30 -> `mem_data0`=70 (memory forward wins). Repeat with rs1=x0 -> uses 0.
- Load-use: `fwd_mem_load`=1, `fwd_mem_reg`=`ex_rs2`=4 -> `ex_stall`=1, `mem_valid`=0 for one cycle. Next cycle it proceeds using `fwd_wb_data`.
- JALR at pc 0x100, rs1=0x2001, imm=4 -> `mem_data0`=0x104, `mem_data1`=0x2004, `mem_jmp`=1. BLT with -1 vs 1 -> `mem_data0`[0]=1.
- `mem_stall` held 3 cycles with `ex_valid`=1 -> `mem_*` unchanged, `ex_stall`=1 throughout. Add `flush` on cycle 2 -> `ex_stall`=0 and `mem_valid`=0 after the stall releases.
- Assert `reset_n`=0 while `mem_valid`=1 and `mem_stall`=1 -> `mem_valid`=0 and all payload outputs 0 after the edge.
